// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port (SETUP/ACCESS sequencing).
// Optional ACCESS-phase timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    // Request channel: a request is transferred in a cycle where req_valid[i] and req_ready[i]
    // are both high; the requester holds req_* stable until then. rsp_valid pulses one cycle.
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_write,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      req_ready,
    output logic [1:0]      rsp_valid,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err,
    output logic [AW-1:0]   PADDR,
    output logic            PWRITE,
    output logic            PSEL,
    output logic            PENABLE,
    output logic [DW-1:0]   PWDATA,
    input  logic [DW-1:0]   PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t          state_q, state_d;
    logic            last_grant, last_grant_d;
    logic            grant;
    logic            any_req;
    logic [AW-1:0]   paddr_d;
    logic [DW-1:0]   pwdata_d;
    logic            pwrite_d;
    logic            psel_d;
    logic            penable_d;
    logic [1:0]      rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_d;
    logic            rsp_err_d;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
`endif

    assign any_req   = |req_valid;
    assign dbg_state = state_q;

    // On a tie the requester that did not win last time takes the port.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
    end

    always_comb begin
        req_ready = 2'b00;
        if (state_q == ST_IDLE && any_req) begin
            req_ready = grant ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant;
        paddr_d      = PADDR;
        pwdata_d     = PWDATA;
        pwrite_d     = PWRITE;
        psel_d       = PSEL;
        penable_d    = PENABLE;
        rsp_valid_d  = 2'b00;
        rsp_rdata_d  = rsp_rdata;
        rsp_err_d    = rsp_err;
`ifdef APB_ARB_TIMEOUT_EN
        wait_cnt_d   = wait_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    last_grant_d = grant;
                    paddr_d      = grant ? req_addr[2*AW-1:AW]  : req_addr[AW-1:0];
                    pwdata_d     = grant ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                    pwrite_d     = grant ? req_write[1]         : req_write[0];
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    state_d      = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            ST_ACCESS: begin
                // last_grant still names the requester that owns this transfer.
                if (PREADY) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = last_grant ? 2'b10 : 2'b01;
                    rsp_rdata_d = PWRITE ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = ST_IDLE;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = last_grant ? 2'b10 : 2'b01;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
`endif
            end

            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            last_grant <= 1'b1;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            last_grant <= last_grant_d;
            PADDR      <= paddr_d;
            PWDATA     <= pwdata_d;
            PWRITE     <= pwrite_d;
            PSEL       <= psel_d;
            PENABLE    <= penable_d;
            rsp_valid  <= rsp_valid_d;
            rsp_rdata  <= rsp_rdata_d;
            rsp_err    <= rsp_err_d;
`ifdef APB_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: timing, arbitration order, errors, reset and ACCESS waiting.
module tb_apb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            PCLK;
    logic            PRESET;
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   PADDR;
    logic            PWRITE;
    logic            PSEL;
    logic            PENABLE;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA;
    logic            PREADY;
    logic            PSLVERR;
    logic [1:0]      dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    apb_master_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .dbg_state (dbg_state)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic saw_rsp;
        PRESET    = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_state", dbg_state, 0);
        PRESET = 1'b0;
        tick();

        // Requester 0 write, zero-wait
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr[31:0]  = 32'h0000_6000;
        req_wdata[31:0] = 32'h1234_5678;
        PREADY = 1'b1;
        #1;
        check("w0_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        check("w0_setup_psel", PSEL, 1);
        check("w0_setup_penable", PENABLE, 0);
        check("w0_paddr", PADDR, 32'h0000_6000);
        check("w0_pwdata", PWDATA, 32'h1234_5678);
        check("w0_pwrite", PWRITE, 1);
        check("w0_setup_ready", req_ready, 0);
        check("w0_setup_state", dbg_state, 1);
        tick();
        check("w0_access_psel", PSEL, 1);
        check("w0_access_penable", PENABLE, 1);
        check("w0_access_state", dbg_state, 2);
        check("w0_access_rsp", rsp_valid, 0);
        tick();
        check("w0_rsp_valid", rsp_valid, 2'b01);
        check("w0_rsp_err", rsp_err, 0);
        check("w0_rsp_rdata", rsp_rdata, 0);
        check("w0_done_psel", PSEL, 0);
        check("w0_done_penable", PENABLE, 0);
        check("w0_done_paddr_held", PADDR, 32'h0000_6000);
        check("w0_done_state", dbg_state, 0);
        tick();
        check("w0_pulse_once", rsp_valid, 0);

        // Requester 1 read with two wait cycles
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[63:32] = 32'h0000_2004;
        PREADY = 1'b0;
        PRDATA = 32'hCAFE_0001;
        #1;
        check("r1_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check("r1_setup_paddr", PADDR, 32'h0000_2004);
        check("r1_setup_pwrite", PWRITE, 0);
        tick();
        check("r1_a1_penable", PENABLE, 1);
        check("r1_a1_paddr", PADDR, 32'h0000_2004);
        tick();
        check("r1_a2_state", dbg_state, 2);
        check("r1_a2_paddr", PADDR, 32'h0000_2004);
        check("r1_a2_rsp", rsp_valid, 0);
        tick();
        PREADY = 1'b1;
        check("r1_a3_state", dbg_state, 2);
        check("r1_a3_paddr", PADDR, 32'h0000_2004);
        tick();
        check("r1_rsp_valid", rsp_valid, 2'b10);
        check("r1_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        check("r1_rsp_err", rsp_err, 0);

        // Slave error on requester 0 read, then clean requester 1 write
        PSLVERR = 1'b1;
        PRDATA  = 32'hDEAD_BEEF;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[31:0] = 32'h0000_0010;
        #1;
        check("e0_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check("e0_rsp_valid", rsp_valid, 2'b01);
        check("e0_rsp_err", rsp_err, 1);
        check("e0_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        PSLVERR = 1'b0;
        req_valid = 2'b10;
        req_write = 2'b10;
        req_addr[63:32]  = 32'h0000_3000;
        req_wdata[63:32] = 32'hA5A5_0F0F;
        #1;
        check("e1_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check("e1_pwdata", PWDATA, 32'hA5A5_0F0F);
        check("e1_pwrite", PWRITE, 1);
        tick();
        tick();
        check("e1_rsp_valid", rsp_valid, 2'b10);
        check("e1_rsp_err", rsp_err, 0);
        check("e1_rsp_rdata", rsp_rdata, 0);
        tick();
        check("e1_rsp_err_held", rsp_err, 0);

        // Both requesters contending: alternate 0,1,0,1 at 3-cycle spacing
        req_write = 2'b00;
        req_addr  = {32'h0000_0200, 32'h0000_0100};
        req_valid = 2'b11;
        PREADY = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [1:0] exp_oh;
            exp_oh = (k % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            check($sformatf("rr%0d_ready", k), req_ready, exp_oh);
            tick();
            if (k == 7) req_valid = 2'b00;
            check($sformatf("rr%0d_paddr", k), PADDR, (k % 2 == 1) ? 32'h0000_0200 : 32'h0000_0100);
            check($sformatf("rr%0d_setup_ready", k), req_ready, 0);
            tick();
            PRDATA = 32'h5555_0000 + 32'(k);
            tick();
            check($sformatf("rr%0d_rsp_valid", k), rsp_valid, exp_oh);
            check($sformatf("rr%0d_rsp_rdata", k), rsp_rdata, 32'h5555_0000 + 32'(k));
        end
        tick();

        // Reset during ACCESS drops the transfer and restores the pointer
        PREADY = 1'b0;
        req_valid = 2'b01;
        req_addr[31:0] = 32'h0000_0400;
        tick();
        req_valid = 2'b00;
        tick();
        check("rm_access_state", dbg_state, 2);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check("rm_psel", PSEL, 0);
        check("rm_penable", PENABLE, 0);
        check("rm_rsp_valid", rsp_valid, 0);
        check("rm_state", dbg_state, 0);
        check("rm_paddr", PADDR, 0);
        PREADY = 1'b1;
        tick();
        check("rm_no_rsp", rsp_valid, 0);
        req_valid = 2'b11;
        #1;
        check("rm_tie_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check("rm_tie_rsp", rsp_valid, 2'b01);
        tick();

        // Requester 1 read with PREADY stuck low
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr[63:32] = 32'h0000_0800;
        tick();
        req_valid = 2'b00;
        tick();
        saw_rsp = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            saw_rsp = saw_rsp | (|rsp_valid);
        end
        check("to_a16_state", dbg_state, 2);
        check("to_early_rsp", saw_rsp, 0);
        tick();
        check("to_rsp_valid", rsp_valid, 2'b10);
        check("to_rsp_err", rsp_err, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        check("to_psel", PSEL, 0);
        check("to_state", dbg_state, 0);
`else
        for (int i = 0; i < 110; i++) begin
            tick();
            saw_rsp = saw_rsp | (|rsp_valid);
        end
        check("stall_psel", PSEL, 1);
        check("stall_penable", PENABLE, 1);
        check("stall_state", dbg_state, 2);
        check("stall_no_rsp", saw_rsp, 0);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check("stall_rst_psel", PSEL, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port (driving apb_bridge_system) between two requesters (index 0 = CPU-side, index 1 = DMA-side).
- Each requester uses a simple valid/ready request channel and a one-cycle response pulse.
- The block round-robin arbitrates between them and sequences the APB SETUP/ACCESS phases.
- It waits on PREADY and returns PRDATA/PSLVERR to the requester that was granted.

Parameters:
- AW, 32, address width of requests and PADDR.
- DW, 32, data width of PWDATA, PRDATA and the response data.
- TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait cycles; used only when APB_ARB_TIMEOUT_EN is defined.

Ports:
- PCLK  in  1  clock; single clock domain.
- PRESET  in  1  reset, synchronous, active-high.
- req_valid  in  2  per-requester request valid.
- req_write  in  2  per-requester direction: 1 = write, 0 = read.
- req_addr  in  2*AW  packed; requester i occupies bits [i*AW +: AW].
- req_wdata  in  2*DW  packed; requester i occupies bits [i*DW +: DW].
- req_ready  out  2  request accepted this cycle; one-hot or zero.
- rsp_valid  out  2  one-cycle response pulse; one-hot or zero.
- rsp_rdata  out  DW  read data for the responding requester.
- rsp_err  out  1  error flag for the responding requester.
- PADDR  out  AW  APB address.
- PWRITE  out  1  APB write.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Round-robin pointer last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, grant g: the only valid requester, or on a tie the one != last_grant.
  - req_ready[g] is combinational: state==IDLE && grant==g. This is the accept cycle.
  - On the edge: latch addr/wdata/write of g into PADDR/PWDATA/PWRITE; last_grant <= g; PSEL <= 1; PENABLE <= 0; go to SETUP.
- SETUP: on the next edge, PENABLE <= 1 and go to ACCESS.
- ACCESS:
  - Hold PSEL=1, PENABLE=1 and PADDR/PWDATA/PWRITE stable.
  - Stay in ACCESS while PREADY=0.
  - On the edge where PREADY=1:
    - PSEL <= 0, PENABLE <= 0.
    - rsp_valid[g] <= 1 for exactly one cycle.
    - rsp_rdata <= PRDATA for reads, 0 for writes.
    - rsp_err <= PSLVERR.
    - Go to IDLE.
- Latency and throughput:
  - With PREADY=1 in the first ACCESS cycle, rsp_valid rises 3 cycles after the accept cycle.
  - A new request may be accepted in the same IDLE cycle in which rsp_valid is high, giving 3 cycles per transfer back-to-back.
- Arbitration and requester rules:
  - Grants never change during SETUP/ACCESS.
  - req_* of non-granted requesters are ignored until IDLE.
  - A requester must hold req_* stable until req_ready.
- After completion, PADDR/PWDATA/PWRITE retain their last values; only PSEL/PENABLE return to 0.
- rsp_rdata and rsp_err hold their values between responses. They are meaningful only while rsp_valid is set.
- Decoding: no address decoding here; the downstream bridge handles region selection. PADDR is passed through unmodified.
- Reset mid-operation: PRESET asserted in any state. On the next edge, all outputs return to reset values and state goes to IDLE. The in-flight transfer is dropped with no rsp_valid.
- Simultaneous events:
  - PRESET wins over everything.
  - In IDLE, a request arriving in the same cycle a response pulses is arbitrated normally.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - If it reaches TIMEOUT_CYCLES with PREADY still 0, the transfer aborts on that edge: PSEL/PENABLE <= 0, rsp_valid[g] <= 1, rsp_err <= 1, rsp_rdata <= 0, go to IDLE.
  - A PREADY=1 seen in the same cycle as expiry takes priority, giving a normal completion.
- When not defined: no counter exists, and ACCESS waits indefinitely for PREADY.

Test Plan:
- Requester 0 write, addr 0x0000_6000, data 0x1234_5678, PREADY tied 1 -> PSEL=1/PENABLE=0 at accept+1, PENABLE=1 at accept+2, rsp_valid=2'b01 at accept+3, rsp_err=0.
- Requester 1 read, addr 0x0000_2004, PREADY low for 2 ACCESS cycles, PRDATA=0xCAFE_0001 -> ACCESS lasts 3 cycles, PADDR stable throughout, rsp_valid=2'b10, rsp_rdata=0xCAFE_0001.
- Both req_valid high from reset, 4 reads each -> grant order 0,1,0,1,...; req_ready never 2'b11; transfers back-to-back at 3-cycle spacing.
- Read with PSLVERR=1 on the PREADY cycle -> rsp_err=1 on that requester's pulse; the next transfer has rsp_err=0.
- PRESET asserted during ACCESS for 1 cycle -> next cycle PSEL=0, PENABLE=0, rsp_valid=0, state IDLE; requester 0 wins the following tie.
- With APB_ARB_TIMEOUT_EN and PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0. Without the macro, PSEL stays high for 100+ cycles.
